// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-through, write-allocate controller
// placed in front of the DataCache block RAM.
//
// Ports
//   clka, rsta              clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata   CPU request, sampled only while cpu_busy=0
//   cpu_rdata, cpu_ready    load data with a one-cycle completion pulse
//   cpu_busy                1 whenever a new request would be ignored
//   dc_ena/wea/addra/dina   DataCache port A controls
//   dc_douta                DataCache read data (1-cycle latency)
//   mem_req/we/addr/wdata   main-memory request, held until mem_ack
//   mem_rdata, mem_ack      main-memory response (ack is one cycle)
//   hit_cnt, miss_cnt       saturating statistics
//
// Build option: define DCACHE_STATS_EN to generate the hit/miss counters;
// without it both counters are tied to zero.
//
// After reset the tag store is swept to invalid, one entry per cycle,
// before the first request is accepted.

module data_cache_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int INDEX_W = 13,
   parameter int DATA_W  = 32
) (
   input  logic               clka,
   input  logic               rsta,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic [DATA_W-1:0]  cpu_rdata,
   output logic               cpu_ready,
   output logic               cpu_busy,
   output logic               dc_ena,
   output logic               dc_wea,
   output logic [INDEX_W-1:0] dc_addra,
   output logic [DATA_W-1:0]  dc_dina,
   input  logic [DATA_W-1:0]  dc_douta,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ack,
   output logic [15:0]        hit_cnt,
   output logic [15:0]        miss_cnt
);

   localparam int TAG_W   = ADDR_W - INDEX_W;
   localparam int ENTRIES = 1 << INDEX_W;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      LOOKUP,
      COMPARE,
      MEM,
      FILL,
      RESP
   } state_t;

   state_t state;

   logic [INDEX_W-1:0] init_cnt;
   logic [ADDR_W-1:0]  addr_q;
   logic               we_q;
   logic [DATA_W-1:0]  wdata_q;

   logic [INDEX_W-1:0] idx_q;
   logic [TAG_W-1:0]   tag_q;

   // Tag entry layout: {valid, tag}
   logic [TAG_W:0]     tag_mem [0:ENTRIES-1];
   logic [TAG_W:0]     tag_rd;
   logic               hit;

   assign idx_q = addr_q[INDEX_W-1:0];
   assign tag_q = addr_q[ADDR_W-1:INDEX_W];

   // tag_rd is sampled at the end of LOOKUP and consumed in COMPARE
   assign hit = tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == tag_q);

   // Tag store: plain synchronous RAM, no reset so it maps to block RAM.
   // The sweep counter and FILL are the only writers.
   always_ff @(posedge clka) begin
      if (state == INIT) begin
         tag_mem[init_cnt] <= '0;
      end else if (state == FILL) begin
         tag_mem[idx_q] <= {1'b1, tag_q};
      end
      tag_rd <= tag_mem[idx_q];
   end

   // Main controller; every output is registered and set on the edge
   // that enters the state it belongs to.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state     <= INIT;
         init_cnt  <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         cpu_busy  <= 1'b1;
         dc_ena    <= 1'b0;
         dc_wea    <= 1'b0;
         dc_addra  <= '0;
         dc_dina   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         unique case (state)
            INIT: begin
               init_cnt <= init_cnt + INDEX_W'(1);
               if (&init_cnt) begin
                  state    <= IDLE;
                  cpu_busy <= 1'b0;
               end
            end

            IDLE: begin
               if (cpu_req) begin
                  addr_q   <= cpu_addr;
                  we_q     <= cpu_we;
                  wdata_q  <= cpu_wdata;
                  cpu_busy <= 1'b1;
                  dc_ena   <= 1'b1;
                  dc_wea   <= 1'b0;
                  dc_addra <= cpu_addr[INDEX_W-1:0];
                  state    <= LOOKUP;
               end
            end

            LOOKUP: begin
               dc_ena <= 1'b0;
               state  <= COMPARE;
            end

            COMPARE: begin
               if (hit && !we_q) begin
                  cpu_rdata <= dc_douta;
                  cpu_ready <= 1'b1;
                  state     <= RESP;
               end else begin
                  // stores always go to memory, hit or miss
                  mem_req   <= 1'b1;
                  mem_we    <= we_q;
                  mem_addr  <= addr_q;
                  mem_wdata <= wdata_q;
                  state     <= MEM;
               end
            end

            MEM: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  if (!we_q) begin
                     cpu_rdata <= mem_rdata;
                  end
                  // dc_dina doubles as the fill register
                  dc_ena   <= 1'b1;
                  dc_wea   <= 1'b1;
                  dc_addra <= idx_q;
                  dc_dina  <= we_q ? wdata_q : mem_rdata;
                  state    <= FILL;
               end
            end

            FILL: begin
               dc_ena    <= 1'b0;
               dc_wea    <= 1'b0;
               cpu_ready <= 1'b1;
               state     <= RESP;
            end

            RESP: begin
               cpu_ready <= 1'b0;
               cpu_busy  <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               state <= INIT;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // Store hits count as hits even though they still go to memory.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == COMPARE) begin
         if (hit) begin
            if (hit_cnt != 16'hFFFF) begin
               hit_cnt <= hit_cnt + 16'd1;
            end
         end else begin
            if (miss_cnt != 16'hFFFF) begin
               miss_cnt <= miss_cnt + 16'd1;
            end
         end
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: directed bench for data_cache_ctrl with a
// DataCache RAM, a main-memory responder and a transparent-cache model.

module tb_data_cache_ctrl;

   logic        clk;
   logic        rsta;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_busy;
   logic        dc_ena;
   logic        dc_wea;
   logic [12:0] dc_addra;
   logic [31:0] dc_dina;
   logic [31:0] dc_douta;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   data_cache_ctrl dut (
      .clka      (clk),
      .rsta      (rsta),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_busy  (cpu_busy),
      .dc_ena    (dc_ena),
      .dc_wea    (dc_wea),
      .dc_addra  (dc_addra),
      .dc_dina   (dc_dina),
      .dc_douta  (dc_douta),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string nm,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // DataCache block RAM: 1-cycle read latency
   logic [31:0] bram [0:8191];
   initial begin
      foreach (bram[i]) bram[i] = '0;
      dc_douta = '0;
   end
   always @(posedge clk) begin
      if (dc_ena) begin
         if (dc_wea) bram[dc_addra] <= dc_dina;
         dc_douta <= bram[dc_addra];
      end
   end

   // Main memory responder
   logic [31:0] env_mem [logic [15:0]];
   int ack_wait = 0;
   initial begin
      int wc;
      wc = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      env_mem[16'h2238] = 32'd120;
      forever begin
         @(posedge clk);
         #1;
         if (rsta) begin
            mem_ack = 1'b0;
            wc = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req) begin
            wc++;
            if (wc > ack_wait) begin
               wc = 0;
               mem_ack = 1'b1;
               if (mem_we) env_mem[mem_addr] = mem_wdata;
               else mem_rdata = env_mem.exists(mem_addr) ?
                                env_mem[mem_addr] : 32'd0;
            end
         end
      end
   end

   // Model: the cache is transparent, so loads return memory contents;
   // a separate valid/tag table predicts hit or miss.
   logic [31:0] ref_mem [logic [15:0]];
   bit          m_valid [0:8191];
   logic [2:0]  m_tag   [0:8191];
   int          m_hits = 0;
   int          m_misses = 0;

   function automatic logic [31:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
   endfunction

   function automatic void model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      foreach (m_tag[i]) m_tag[i] = '0;
      m_hits = 0;
      m_misses = 0;
   endfunction

   // Expectations for the transaction in flight
   bit          sweeping = 1'b0;
   bit          run = 1'b0;
   int          exp_ready = -1;
   logic        e_we = 1'b0;
   logic [15:0] e_addr = '0;
   logic [31:0] e_wdata = '0;
   logic [31:0] e_data = '0;
   int          rdy_count = 0;
   int          rdy_cyc = 0;
   int          mreq_total = 0;

   always @(negedge clk) begin
      if (!rsta && run) begin
         if (sweeping) begin
            chk(!dc_ena && !dc_wea && !mem_req && !cpu_ready,
                "sweep_quiet", {dc_ena, dc_wea, mem_req, cpu_ready}, 0);
         end else begin
            chk(cpu_ready == (cyc == exp_ready), "ready_timing",
                cpu_ready, cyc == exp_ready);
            if (cpu_ready) begin
               rdy_count++;
               rdy_cyc = cyc;
               if (!e_we) chk(cpu_rdata == e_data, "rdata",
                              cpu_rdata, e_data);
            end
            if (mem_req) begin
               mreq_total++;
               chk(mem_addr == e_addr && mem_we == e_we &&
                   (!e_we || mem_wdata == e_wdata), "mem_cmd",
                   {mem_we, mem_addr}, {e_we, e_addr});
            end
            if (dc_ena) chk(dc_addra == e_addr[12:0], "dc_addra",
                            dc_addra, e_addr[12:0]);
            if (dc_ena && dc_wea) chk(dc_dina == e_data, "fill_data",
                                      dc_dina, e_data);
         end
      end
   end

   task automatic sweep_check();
      int n;
      n = 0;
      sweeping = 1'b1;
      while (n < 10000) begin
         @(negedge clk);
         n++;
         if (!cpu_busy) break;
      end
      sweeping = 1'b0;
      chk(n == 8192, "sweep_len", n, 8192);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (cpu_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(!cpu_busy, "idle_timeout", cpu_busy, 0);
   endtask

   task automatic xact(input logic we, input logic [15:0] addr,
                       input logic [31:0] wd, input int wt,
                       input bit pulse, output int lat_o,
                       output logic [31:0] d_o, output int mr_o);
      int n, r0, m0, ck;
      bit thit, hit;
      logic [12:0] idx;
      idx = addr[12:0];
      thit = m_valid[idx] && m_tag[idx] == addr[15:13];
      hit = thit && !we;
      wait_idle();
      ack_wait = wt;
      e_we = we;
      e_addr = addr;
      e_wdata = wd;
      e_data = we ? wd : ref_rd(addr);
      r0 = rdy_count;
      m0 = mreq_total;
      ck = cyc + 1;
      exp_ready = ck + (hit ? 2 : 4 + wt);
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = addr;
      cpu_wdata = wd;
      @(negedge clk);
      cpu_req = 1'b0;
      if (pulse) begin
         @(negedge clk);
         cpu_req = 1'b1;
         cpu_addr = addr ^ 16'h0001;
         @(negedge clk);
         cpu_req = 1'b0;
      end
      n = 0;
      while (rdy_count == r0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(rdy_count != r0, "ready_timeout", rdy_count - r0, 1);
      @(negedge clk);
      chk(rdy_count - r0 == 1, "ready_once", rdy_count - r0, 1);
      lat_o = rdy_cyc - ck;
      d_o = cpu_rdata;
      mr_o = mreq_total - m0;
      chk(mr_o == (hit ? 0 : wt + 1), "mem_req_len", mr_o,
          hit ? 0 : wt + 1);
      if (we) ref_mem[addr] = wd;
      if (!hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx] = addr[15:13];
      end
      if (thit) m_hits++;
      else m_misses++;
`ifdef DCACHE_STATS_EN
      chk(hit_cnt == 16'(m_hits), "hit_cnt", hit_cnt, m_hits);
      chk(miss_cnt == 16'(m_misses), "miss_cnt", miss_cnt, m_misses);
`else
      chk(hit_cnt == 0 && miss_cnt == 0, "stats_off",
          {hit_cnt, miss_cnt}, 0);
`endif
   endtask

   initial begin
      int lat, mr, n;
      logic [31:0] d;
      rsta = 1'b1;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      ref_mem[16'h2238] = 32'd120;
      model_reset();
      repeat (3) @(negedge clk);

      chk(cpu_busy == 1'b1, "rst_busy", cpu_busy, 1);
      chk(!cpu_ready && cpu_rdata == 0, "rst_cpu", cpu_rdata, 0);
      chk(!dc_ena && !dc_wea && dc_addra == 0 && dc_dina == 0,
          "rst_dc", dc_dina, 0);
      chk(!mem_req && !mem_we && mem_addr == 0 && mem_wdata == 0,
          "rst_mem", mem_addr, 0);
      chk(hit_cnt == 0 && miss_cnt == 0, "rst_stats",
          {hit_cnt, miss_cnt}, 0);

      run = 1'b1;
      rsta = 1'b0;
      sweep_check();

      xact(1'b1, 16'h0238, 32'd500, 0, 1'b0, lat, d, mr);
      chk(lat == 4, "store_lat", lat, 4);
      chk(mr == 1, "store_mreq", mr, 1);

      xact(1'b0, 16'h0238, 32'd0, 0, 1'b0, lat, d, mr);
      chk(lat == 2, "hit_lat", lat, 2);
      chk(d == 32'd500, "hit_data", d, 500);
`ifdef DCACHE_STATS_EN
      chk(hit_cnt == 16'd1, "hit_cnt_lit", hit_cnt, 1);
`endif

      xact(1'b0, 16'h2238, 32'd0, 3, 1'b1, lat, d, mr);
      chk(lat == 7, "miss_lat", lat, 7);
      chk(mr == 4, "miss_mreq", mr, 4);
      chk(d == 32'd120, "miss_data", d, 120);

      xact(1'b0, 16'h0238, 32'd0, 0, 1'b0, lat, d, mr);
      chk(mr == 1, "replaced_mreq", mr, 1);
      chk(d == 32'd500, "replaced_data", d, 500);

      xact(1'b1, 16'h0238, 32'd600, 1, 1'b0, lat, d, mr);
      chk(lat == 5, "store_hit_lat", lat, 5);
      xact(1'b0, 16'h0238, 32'd0, 0, 1'b0, lat, d, mr);
      chk(d == 32'd600, "store_hit_data", d, 600);

      xact(1'b1, 16'h1FFF, 32'hDEADBEEF, 0, 1'b0, lat, d, mr);
      xact(1'b0, 16'h1FFF, 32'd0, 0, 1'b0, lat, d, mr);
      chk(mr == 0 && d == 32'hDEADBEEF, "top_idx_hit", d, 32'hDEADBEEF);
      xact(1'b1, 16'hFFFF, 32'd7, 2, 1'b0, lat, d, mr);
      xact(1'b0, 16'h1FFF, 32'd0, 0, 1'b0, lat, d, mr);
      chk(mr == 1 && d == 32'hDEADBEEF, "top_idx_miss", d, 32'hDEADBEEF);

      // Abort a load in MEM with reset
      wait_idle();
      ack_wait = 20;
      e_we = 1'b0;
      e_addr = 16'h2238;
      e_data = ref_rd(16'h2238);
      exp_ready = -1;
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 16'h2238;
      @(negedge clk);
      cpu_req = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(mem_req, "abort_mreq_seen", mem_req, 1);
      #2 rsta = 1'b1;
      #1;
      chk(!mem_req, "abort_async_drop", mem_req, 0);
      chk(cpu_busy && !cpu_ready, "abort_busy", {cpu_busy, cpu_ready}, 2);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rsta = 1'b0;
      sweep_check();

      xact(1'b0, 16'h2238, 32'd0, 1, 1'b0, lat, d, mr);
      chk(mr == 2, "post_rst_miss", mr, 2);
      chk(d == 32'd120, "post_rst_data", d, 120);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
